// File: rtl/citron_timer_pkg.sv
// citron_timer_pkg
// Shared definitions for the Citron-bus timer: register word offsets within
// the 8-word window, CTRL bit positions, the packed CTRL register type and a
// helper that formats CTRL for read-back.
package citron_timer_pkg;

    // Word offsets from BASE
    localparam logic [2:0] CTRL     = 3'd0;
    localparam logic [2:0] PRESCALE = 3'd1;
    localparam logic [2:0] COUNT_LO = 3'd2;
    localparam logic [2:0] COUNT_HI = 3'd3;
    localparam logic [2:0] CMP_LO   = 3'd4;
    localparam logic [2:0] CMP_HI   = 3'd5;
    localparam logic [2:0] STATUS   = 3'd6;

    // CTRL bit indices
    localparam int EN         = 0;
    localparam int IRQ_EN     = 1;
    localparam int AUTORELOAD = 2;

    // Member order puts autoreload at bit 2 and en at bit 0
    typedef struct packed {
        logic autoreload;
        logic irq_en;
        logic en;
    } ctrl_t;

    // CTRL as seen on the bus: unused bits read back as 0
    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        return {29'd0, c};
    endfunction

endpackage

// File: rtl/citron_timer_prescaler.sv
// citron_timer_prescaler
// Divides clk by (prescale+1). While en is high the internal counter runs
// 0..prescale and tick pulses in the cycle it equals prescale, then the
// counter returns to 0. en low freezes the counter. clr forces the counter
// back to 0 and suppresses the tick of that cycle.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   en       in   count enable
//   prescale in   terminal count
//   clr      in   synchronous restart from 0
//   tick     out  one-cycle pulse per prescale period
module citron_timer_prescaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] prescale,
    input  logic         clr,
    output logic         tick
);

    logic [W-1:0] cnt_reg;
    logic         at_top;

    assign at_top = (cnt_reg == prescale);
    assign tick   = en & ~clr & at_top;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= at_top ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/citron_timer.sv
// citron_timer
// Citron-bus timer slave: prescaled 64-bit up-counter, 64-bit compare with
// optional auto-reload, sticky match flag (write-1-to-clear) and a
// registered level interrupt. Decodes the 8-word window BASE..BASE+7.
// Ports:
//   clk               in   system clock
//   rst_n             in   asynchronous active-low reset
//   citron_addr       in   word address, held for the whole transaction
//   citron_rdy        in   one-cycle access strobe
//   citron_wr         in   1 = write, 0 = read
//   citron_writedata  in   write data
//   citron_readdata   out  captured read data, 0 when not addressed
//   citron_stall      out  always 0
//   citron_match      out  address falls in this device's window
//   irq               out  registered STATUS.flag & CTRL.irq_en
module citron_timer
    import citron_timer_pkg::*;
#(
    parameter logic [7:0] BASE       = 8'h10,
    parameter int         PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  citron_addr,
    input  logic        citron_rdy,
    input  logic        citron_wr,
    input  logic [31:0] citron_writedata,
    output logic [31:0] citron_readdata,
    output logic        citron_stall,
    output logic        citron_match,
    output logic        irq
);

    logic [2:0]            offset;
    logic                  wr_en;
    logic                  rd_en;
    ctrl_t                 ctrl_reg;
    logic [PRESCALE_W-1:0] prescale_reg;
    logic [63:0]           count_reg;
    logic [63:0]           cmp_reg;
    logic [63:0]           count_next;
    logic [31:0]           shadow_hi_reg;
    logic [31:0]           rdata_reg;
    logic [31:0]           read_val;
    logic                  flag_reg;
    logic                  irq_reg;
    logic                  tick;
    logic                  presc_clr;
    logic                  flag_set;

    assign offset       = citron_addr[2:0];
    assign citron_match = (citron_addr[7:3] == BASE[7:3]);
    assign wr_en        = citron_rdy & citron_match & citron_wr;
    assign rd_en        = citron_rdy & citron_match & ~citron_wr;

    // Restart the prescaler on a PRESCALE write, and on en 0->1 so the
    // first tick always lands PRESCALE+1 cycles after enabling.
    assign presc_clr = (wr_en && offset == PRESCALE) ||
                       (wr_en && offset == CTRL && citron_writedata[EN] && !ctrl_reg.en);

    citron_timer_prescaler #(.W(PRESCALE_W)) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (ctrl_reg.en),
        .prescale (prescale_reg),
        .clr      (presc_clr),
        .tick     (tick)
    );

    assign flag_set   = tick && (count_reg == cmp_reg);
    assign count_next = (flag_set && ctrl_reg.autoreload) ? 64'd0 : count_reg + 64'd1;

    // Counter and compare are held as two independent 32-bit halves so a
    // bus write to one half overrides that half's increment only.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_half
            localparam logic [2:0] CNT_OFF = (gi == 0) ? COUNT_LO : COUNT_HI;
            localparam logic [2:0] CMP_OFF = (gi == 0) ? CMP_LO : CMP_HI;
            logic [31:0] count_half_reg;
            logic [31:0] cmp_half_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_half_reg <= '0;
                    cmp_half_reg   <= '0;
                end else begin
                    if (wr_en && offset == CNT_OFF) begin
                        count_half_reg <= citron_writedata;
                    end else if (tick) begin
                        count_half_reg <= count_next[gi*32 +: 32];
                    end
                    if (wr_en && offset == CMP_OFF) begin
                        cmp_half_reg <= citron_writedata;
                    end
                end
            end

            assign count_reg[gi*32 +: 32] = count_half_reg;
            assign cmp_reg[gi*32 +: 32]   = cmp_half_reg;
        end
    endgenerate

    always_comb begin
        read_val = '0;
        case (offset)
            CTRL:     read_val = ctrl_word(ctrl_reg);
            PRESCALE: read_val = 32'(prescale_reg);
            COUNT_LO: read_val = count_reg[31:0];
            COUNT_HI: read_val = shadow_hi_reg;
            CMP_LO:   read_val = cmp_reg[31:0];
            CMP_HI:   read_val = cmp_reg[63:32];
            STATUS:   read_val = {31'd0, flag_reg};
            default:  read_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_reg      <= '0;
            prescale_reg  <= '0;
            flag_reg      <= 1'b0;
            shadow_hi_reg <= '0;
            rdata_reg     <= '0;
            irq_reg       <= 1'b0;
        end else begin
            if (wr_en && offset == CTRL) begin
                ctrl_reg.en         <= citron_writedata[EN];
                ctrl_reg.irq_en     <= citron_writedata[IRQ_EN];
                ctrl_reg.autoreload <= citron_writedata[AUTORELOAD];
            end
            if (wr_en && offset == PRESCALE) begin
                prescale_reg <= citron_writedata[PRESCALE_W-1:0];
            end
            // A compare hit beats a simultaneous write-1-to-clear
            if (flag_set) begin
                flag_reg <= 1'b1;
            end else if (wr_en && offset == STATUS && citron_writedata[0]) begin
                flag_reg <= 1'b0;
            end
            if (rd_en) begin
                rdata_reg <= read_val;
                // LO read freezes the upper word so a following HI read is
                // coherent with it even if a carry happens in between
                if (offset == COUNT_LO) begin
                    shadow_hi_reg <= count_reg[63:32];
                end
            end
            irq_reg <= flag_reg & ctrl_reg.irq_en;
        end
    end

    assign citron_readdata = citron_match ? rdata_reg : 32'd0;
    assign citron_stall    = 1'b0;
    assign irq             = irq_reg;

endmodule
